// File: rtl/oto_pilot_pkg.sv
// Shared types and encodings for the altitude-hold autopilot core.
package oto_pilot_pkg;

    localparam int ALT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        CLIMB,
        HOLD,
        DESCEND
    } state_t;

    localparam logic [2:0] CMD_IDLE    = 3'b000;
    localparam logic [2:0] CMD_CLIMB   = 3'b001;
    localparam logic [2:0] CMD_HOLD    = 3'b010;
    localparam logic [2:0] CMD_DESCEND = 3'b100;

    function automatic logic [2:0] state_to_cmd(input state_t s);
        logic [2:0] cmd;
        cmd = CMD_IDLE;
        case (s)
            CLIMB:   cmd = CMD_CLIMB;
            HOLD:    cmd = CMD_HOLD;
            DESCEND: cmd = CMD_DESCEND;
            default: cmd = CMD_IDLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/oto_pilot_altitude_ctrl_fuse.sv
// Stage 1: fuses GNSS and barometric altitude, flags sensor disagreement.
module alt_sensor_fuse
    import oto_pilot_pkg::*;
#(
    parameter int MAX_DIFF = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [ALT_W-1:0] gnss,
    input  logic [ALT_W-1:0] altimetre,
    input  logic [ALT_W-1:0] target,
    output logic [ALT_W-1:0] fused_p1,
    output logic [ALT_W-1:0] target_p1,
    output logic             fault_p1,
    output logic             vld_p1
);

    localparam int DW = ALT_W + 1;
    localparam logic signed [DW-1:0] MAX_DIFF_S = DW'(MAX_DIFF);

    function automatic logic signed [DW-1:0] abs_diff(input logic [ALT_W-1:0] a,
                                                      input logic [ALT_W-1:0] b);
        logic signed [DW-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DW-1] ? -d : d;
    endfunction

    // Sum kept one bit wider so the halved result is a floor with no wrap.
    function automatic logic [ALT_W-1:0] floor_avg(input logic [ALT_W-1:0] a,
                                                   input logic [ALT_W-1:0] b);
        logic [ALT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ALT_W:1];
    endfunction

    logic signed [DW-1:0] diff_s;
    logic                 fault_s;
    logic [ALT_W-1:0]     fused_s;

    always_comb begin
        diff_s  = abs_diff(gnss, altimetre);
        fault_s = (diff_s > MAX_DIFF_S);
        fused_s = fault_s ? altimetre : floor_avg(gnss, altimetre);
    end

    // ---- stage 1 boundary ----
    always_ff @(posedge clk) begin
        if (strobe) begin
            fused_p1  <= fused_s;
            target_p1 <= target;
            fault_p1  <= fault_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= strobe;
        end
    end

endmodule

// File: rtl/oto_pilot_altitude_ctrl.sv
// Altitude-hold core: compares the fused altitude to target and drives a one-hot
// climb/hold/descend command, dropping to idle when altitude info goes stale.
module oto_pilot_altitude_ctrl
    import oto_pilot_pkg::*;
#(
    parameter int DEADBAND = 1,
    parameter int MAX_DIFF = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [ALT_W-1:0] gnss_i,
    input  logic [ALT_W-1:0] altimetre_i,
    input  logic [ALT_W-1:0] hedef_yukseklik_i,
    input  logic             yukseklik_bilgisi_i,
    output logic [2:0]       komut_o,
    output logic             sensor_fault_o
);

    localparam int CNT_W = 10;
    localparam int EW    = ALT_W + 1;
    localparam logic [CNT_W-1:0]    TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic signed [EW-1:0] DB_S      = EW'(DEADBAND);

    logic [ALT_W-1:0] fused_p1;
    logic [ALT_W-1:0] target_p1;
    logic             fault_p1;
    logic             vld_p1;

    alt_sensor_fuse #(
        .MAX_DIFF (MAX_DIFF)
    ) u_fuse (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .strobe    (yukseklik_bilgisi_i),
        .gnss      (gnss_i),
        .altimetre (altimetre_i),
        .target    (hedef_yukseklik_i),
        .fused_p1  (fused_p1),
        .target_p1 (target_p1),
        .fault_p1  (fault_p1),
        .vld_p1    (vld_p1)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == TIMEOUT_C) ? c : c + CNT_W'(1);
    endfunction

    function automatic state_t classify(input logic signed [EW-1:0] e);
        state_t s;
        if (e < -DB_S)
            s = CLIMB;
        else if (e > DB_S)
            s = DESCEND;
        else
            s = HOLD;
        return s;
    endfunction

    logic signed [EW-1:0] err_s;
    logic [CNT_W-1:0]     stale_cnt;
    logic                 timeout_hit;
    state_t               state;
    state_t               state_next;
    logic                 fault_next;

    always_comb begin
        err_s       = $signed({1'b0, fused_p1}) - $signed({1'b0, target_p1});
        timeout_hit = !yukseklik_bilgisi_i && (stale_cnt >= TIMEOUT_M1);
        state_next  = state;
        fault_next  = sensor_fault_o;
        // A fresh sample always wins; the timeout only acts on a quiet pipeline.
        if (vld_p1) begin
            state_next = classify(err_s);
            fault_next = fault_p1;
        end else if (timeout_hit) begin
            state_next = IDLE;
            fault_next = 1'b0;
        end
    end

    // ---- stage 2 boundary ----
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            komut_o        <= CMD_IDLE;
            sensor_fault_o <= 1'b0;
            stale_cnt      <= '0;
        end else begin
            state          <= state_next;
            komut_o        <= state_to_cmd(state_next);
            sensor_fault_o <= fault_next;
            stale_cnt      <= yukseklik_bilgisi_i ? '0 : sat_inc(stale_cnt);
        end
    end

endmodule

// File: tb/tb_oto_pilot_altitude_ctrl.sv
// Scoreboard bench for oto_pilot_altitude_ctrl: expected commands queued at drive, checked two edges later.
module tb_oto_pilot_altitude_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] gnss;
    logic [5:0] alt;
    logic [5:0] tgt;
    logic       vld;
    logic [2:0] komut;
    logic       flt;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         due;
        logic [2:0] cmd;
        logic       flt;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oto_pilot_altitude_ctrl dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .gnss_i              (gnss),
        .altimetre_i         (alt),
        .hedef_yukseklik_i   (tgt),
        .yukseklik_bilgisi_i (vld),
        .komut_o             (komut),
        .sensor_fault_o      (flt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model(input int g, input int a, input int t,
                                  output logic [2:0] c, output logic f);
        int d, fu, e;
        d = (g > a) ? g - a : a - g;
        if (d > 8) begin
            fu = a;
            f  = 1'b1;
        end else begin
            fu = (g + a) / 2;
            f  = 1'b0;
        end
        e = fu - t;
        if (e < -1)
            c = 3'b001;
        else if (e > 1)
            c = 3'b100;
        else
            c = 3'b010;
    endfunction

    // Called at a negedge: drive one cycle of stimulus, advance, then retire due entries.
    task automatic cycle(input int g, input int a, input int t, input bit v, input string tag);
        exp_t x;
        gnss = 6'(g);
        alt  = 6'(a);
        tgt  = 6'(t);
        vld  = v;
        if (v) begin
            model(g, a, t, x.cmd, x.flt);
            x.due = cyc + 2;
            x.tag = tag;
            sb.push_back(x);
        end
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            check({x.tag, "_cmd"}, 32'(komut), 32'(x.cmd));
            check({x.tag, "_flt"}, 32'(flt), 32'(x.flt));
            check({x.tag, "_onehot"}, 32'($countones(komut) <= 1), 32'd1);
        end
    endtask

    int tg[11] = '{13, 50, 50, 30, 30, 60,  0,  0, 20, 20,  9};
    int ta[11] = '{12, 50, 50, 31, 38, 10,  0,  0, 20, 20,  0};
    int tt[11] = '{47, 20, 49, 30, 30, 20,  0, 63, 21, 22, 63};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int g, a, t;
        bit v;
        rst  = 1'b1;
        gnss = '0;
        alt  = '0;
        tgt  = '0;
        vld  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cmd", 32'(komut), 32'd0);
        check("reset_flt", 32'(flt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_release_cmd", 32'(komut), 32'd0);

        // Back-to-back directed table: a new command each cycle.
        for (int i = 0; i < 11; i++)
            cycle(tg[i], ta[i], tt[i], 1'b1, $sformatf("tbl%0d", i));
        cycle(0, 0, 0, 1'b0, "flush");
        cycle(0, 0, 0, 1'b0, "flush");

        // Random samples with gaps in the strobe.
        for (int i = 0; i < 24; i++) begin
            g = $urandom_range(0, 63);
            a = (i % 2 == 0) ? $urandom_range(0, 63) : g ^ int'($urandom_range(0, 7));
            t = $urandom_range(0, 63);
            v = ($urandom_range(0, 3) != 0);
            cycle(g, a, t, v, $sformatf("rnd%0d", i));
        end
        cycle(0, 0, 0, 1'b0, "flush");
        cycle(0, 0, 0, 1'b0, "flush");

        // Stale-data timeout after a climb with a sensor fault.
        cycle(60, 10, 20, 1'b1, "to_pre");
        for (int i = 0; i < 1022; i++)
            cycle(0, 0, 0, 1'b0, "to_low");
        check("to_1022_cmd", 32'(komut), 32'd1);
        check("to_1022_flt", 32'(flt), 32'd1);
        cycle(0, 0, 0, 1'b0, "to_low");
        check("to_1023_cmd", 32'(komut), 32'd0);
        check("to_1023_flt", 32'(flt), 32'd0);
        cycle(13, 12, 47, 1'b1, "to_resume");
        check("to_resume_lat", 32'(komut), 32'd0);
        cycle(0, 0, 0, 1'b0, "flush");
        cycle(0, 0, 0, 1'b0, "flush");

        // Asynchronous reset while descending, with a sample in flight.
        cycle(50, 50, 20, 1'b1, "pre_rst");
        cycle(50, 50, 20, 1'b1, "pre_rst");
        cycle(0, 0, 0, 1'b0, "flush");
        cycle(0, 0, 0, 1'b0, "flush");
        gnss = 6'd13;
        alt  = 6'd12;
        tgt  = 6'd47;
        vld  = 1'b1;
        @(posedge clk);
        #2;
        vld = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_cmd", 32'(komut), 32'd0);
        check("async_rst_flt", 32'(flt), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", i), 32'(komut), 32'd0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oto_pilot_altitude_ctrl.md
Name: oto_pilot_altitude_ctrl

Overview:
Altitude-hold autopilot core inside the user project area of the SoC. It fuses two 6-bit altitude sensors (GNSS and altimeter) and compares the result with a 6-bit target altitude. From that it issues a one-hot vertical command (climb / hold / descend) on three user IO pins (mprj_io[10:8]). Inputs are sampled only while the altitude-info-valid strobe is high; stale data drops the command to idle.

Parameters:
DEADBAND, 1, hold band: |fused - target| <= DEADBAND gives HOLD
MAX_DIFF, 8, max |gnss - altimetre| before a sensor-disagreement fault
TIMEOUT, 1023, consecutive cycles with valid low before forcing IDLE (10-bit counter)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous, active-high reset
gnss_i  in  6  GNSS altitude, unsigned (mprj_io[18:13])
altimetre_i  in  6  barometric altimeter altitude, unsigned (mprj_io[24:19])
hedef_yukseklik_i  in  6  target altitude, unsigned (mprj_io[30:25])
yukseklik_bilgisi_i  in  1  altitude-info valid strobe (mprj_io[31])
komut_o  out  3  one-hot command: 001 climb, 010 hold, 100 descend, 000 idle (mprj_io[10:8])
sensor_fault_o  out  1  sensor disagreement on the last accepted sample

Behaviour:
- Reset (async assert, synchronous release on wb_clk_i): komut_o = 000, sensor_fault_o = 0, state IDLE, pipeline valid flags 0, timeout counter 0.
- Stage 1 registers, on any cycle with yukseklik_bilgisi_i = 1:
  - Capture gnss, altimetre and target.
  - diff_s = |gnss - altimetre| in 7-bit arithmetic.
  - If diff_s > MAX_DIFF: fused = altimetre and fault = 1.
  - Otherwise: fused = (gnss + altimetre) >> 1, with a 7-bit sum, so the result is floored and cannot overflow. fault = 0.
  - Set s1_valid = 1. When the strobe is low, s1_valid = 0 and the captured data holds.
- Stage 2 registers, when s1_valid = 1:
  - err = fused - target as 7-bit signed.
  - err < -DEADBAND → CLIMB (001).
  - err > DEADBAND → DESCEND (100).
  - Otherwise → HOLD (010).
  - sensor_fault_o is updated from the stage-1 fault in the same cycle.
- Latency: komut_o reflects a sample exactly 2 clock edges after the edge that accepted it. A continuous strobe gives a new command every cycle.
- State machine IDLE/CLIMB/HOLD/DESCEND:
  - Any state may go to any of CLIMB/HOLD/DESCEND directly on a stage-2 update.
  - There is no hysteresis beyond DEADBAND.
  - komut_o is a registered decode of the state; IDLE decodes to 000.
- Timeout:
  - The counter increments on each cycle with the strobe low and saturates at TIMEOUT.
  - It clears to 0 when the strobe is high.
  - On reaching TIMEOUT the state goes to IDLE and sensor_fault_o clears.
  - A later valid sample leaves IDLE through the normal 2-cycle pipeline.
- Boundaries:
  - target = 0 with fused = 0 → HOLD.
  - target = 63 with fused = 0 → err = -63 → CLIMB.
  - Exactly |err| = DEADBAND → HOLD.
  - Exactly diff = MAX_DIFF → no fault, average used.
- Reset mid-operation: all outputs go to 000/0 immediately (async) and in-flight pipeline samples are discarded.
- Outputs never carry X after reset. komut_o never has more than one bit set.

Decomposition:
- Package oto_pilot_pkg holds:
  - the state enum (IDLE, CLIMB, HOLD, DESCEND);
  - the command encodings CMD_IDLE = 3'b000, CMD_CLIMB = 3'b001, CMD_HOLD = 3'b010, CMD_DESCEND = 3'b100;
  - the altitude width ALT_W = 6.
- One sub-module, alt_sensor_fuse: the stage-1 logic (difference, fault check, averaging, s1 registers).
- The top-level block holds the comparator, state machine and timeout counter.

Test Plan:
1. gnss = 13, altimetre = 12, target = 47, strobe = 1 → fused 12, komut_o = 001 two cycles later, sensor_fault_o = 0.
2. gnss = 50, altimetre = 50, target = 20, strobe = 1 → komut_o = 100. Then target = 49 → 010 (err = 1 = DEADBAND).
3. gnss = 30, altimetre = 31, target = 30 → fused 30 → 010. Then gnss = 30, altimetre = 38 (diff 8) → fused 34 → 100, fault = 0.
4. gnss = 60, altimetre = 10, target = 20 → diff 50 > 8 → fused 10 → komut_o = 001, sensor_fault_o = 1.
5. After a 001 command, drop the strobe:
   - after 1022 cycles low, still 001;
   - at 1023 cycles low → 000 with fault cleared;
   - reassert the strobe with the case 1 values → 001 two cycles later.
6. Assert wb_rst_i asynchronously between clock edges while komut_o = 100 → 000 immediately. A sample accepted in the edge before reset does not appear after release.
